fetch_redirect: RTL and testbench

Instruction-fetch stage of the RISC-V pipeline. Owns the program counter, drives a single-outstanding instruction-memory request interface, and loads the IF/ID pipeline register. It consumes the branch-taken decision from the EX-stage branch comparator and the jump/target from EX, then redirects fetch and raises the flush that squashes the wrong-path instructions.

---
 rtl/fetch_redirect_pkg.sv | 27 ++
 rtl/fetch_perf_cnt.sv | 31 +++
 rtl/fetch_redirect.sv | 176 +++++++++++++++++
 tb/tb_fetch_redirect.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_pkg.sv
// ---------------------------------------------------------------------------
// fetch_redirect_pkg
//   Shared types and constants for the instruction-fetch stage:
//   - fetch_state_e    : fetch FSM states (S_REQ, S_WAIT, S_HOLD)
//   - NOP_INSTR        : canonical RISC-V NOP (addi x0, x0, 0)
//   - PC_STEP          : sequential PC increment
//   - DEFAULT_RESET_PC : default PC after reset
//   - align_pc()       : clears the two low address bits of a target
// ---------------------------------------------------------------------------
package fetch_redirect_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instructions are word aligned; the low two target bits are ignored.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// ---------------------------------------------------------------------------
// fetch_perf_cnt
//   Two free-running 32-bit event counters for the fetch stage. Both wrap
//   modulo 2^32 and clear on reset.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     redirect_evt    : one redirect this cycle
//     kill_evt        : one fetch response dropped this cycle
//     redirect_cnt    : number of redirect cycles seen
//     kill_cnt        : number of dropped responses seen
// ---------------------------------------------------------------------------
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_evt,
    input  logic        kill_evt,
    output logic [31:0] redirect_cnt,
    output logic [31:0] kill_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt <= '0;
            kill_cnt     <= '0;
        end else begin
            if (redirect_evt) redirect_cnt <= redirect_cnt + 32'd1;
            if (kill_evt)     kill_cnt     <= kill_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_redirect.sv
// ---------------------------------------------------------------------------
// fetch_redirect
//   Instruction-fetch stage: owns the PC, issues single-outstanding requests
//   to instruction memory, loads the IF/ID register, and redirects fetch on a
//   taken branch or jump from EX while raising flush for the wrong path.
//
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     stall               : hazard unit holds IF/ID
//     br_en, ba, jmp      : EX branch / taken decision / jump
//     br_target           : redirect target from EX (low 2 bits ignored)
//     imem_req/imem_addr  : fetch request and address
//     imem_ready          : request accepted this cycle
//     imem_rvalid/rdata   : fetch response
//     if_valid/if_pc/if_instr : IF/ID pipeline register
//     flush               : squash IF/ID and ID/EX this cycle
//
//   Optional build macro FETCH_PERF_CNT_EN adds redirect_cnt[31:0] and
//   kill_cnt[31:0] event counters.
// ---------------------------------------------------------------------------
module fetch_redirect
    import fetch_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_en,
    input  logic        ba,
    input  logic        jmp,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] redirect_cnt,
    output logic [31:0] kill_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic [31:0]  skid_q;

    logic         redirect;
    logic [31:0]  target;
    logic         load;
    logic [31:0]  load_instr;
    logic         skid_we;

    assign redirect  = (br_en & ba) | jmp;
    assign target    = align_pc(br_target);
    assign flush     = redirect & rst_n;
    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;

    // Next-state / datapath control.
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        load       = 1'b0;
        load_instr = imem_rdata;
        skid_we    = 1'b0;

        case (state_q)
            S_REQ: begin
                if (imem_ready) begin
                    state_d = S_WAIT;
                    // The old request is already accepted; its reply must go.
                    if (redirect) kill_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect || kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (!stall) begin
                        load    = 1'b1;
                        pc_d    = pc_q + PC_STEP;
                        state_d = S_REQ;
                    end else begin
                        skid_we = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_d = S_REQ;
                end else if (!stall) begin
                    load       = 1'b1;
                    load_instr = skid_q;
                    pc_d       = pc_q + PC_STEP;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Redirect wins over every sequential update of the PC.
        if (redirect) pc_d = target;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
        end
    end

    // NOTE: the skid buffer is pure data qualified by S_HOLD, so it needs no
    // reset; leaving it out keeps the reset net off the data flops.
    always_ff @(posedge clk) begin
        if (skid_we) skid_q <= imem_rdata;
    end

    // IF/ID register: redirect squashes, stall holds, otherwise load or bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_pc    <= RESET_PC;
            if_instr <= NOP_INSTR;
        end else if (redirect) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
        end else if (load) begin
            if_valid <= 1'b1;
            if_pc    <= pc_q;
            if_instr <= load_instr;
        end else if (!stall) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic kill_evt;

    // A response is dropped when it returns under kill_q or alongside a
    // redirect, or when a parked response is discarded by a redirect.
    assign kill_evt = ((state_q == S_WAIT) && imem_rvalid && (redirect || kill_q))
                    || ((state_q == S_HOLD) && redirect);

    fetch_perf_cnt u_perf_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect_evt (redirect),
        .kill_evt     (kill_evt),
        .redirect_cnt (redirect_cnt),
        .kill_cnt     (kill_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_redirect.sv
// ---------------------------------------------------------------------------
// tb_fetch_redirect
//   Directed bench for fetch_redirect. The memory model accepts whenever
//   'ready' is high and answers one cycle later with data = addr + 0x00500093,
//   so addr 0 returns 0x00500093. Inputs are driven and outputs sampled 1 ns
//   after the rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_redirect;
    import fetch_redirect_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_en;
    logic        ba;
    logic        jmp;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        ready;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] redirect_cnt;
    logic [31:0] kill_cnt;
`endif

    int vectors;
    int miscompares;

    fetch_redirect #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .br_en       (br_en),
        .ba          (ba),
        .jmp         (jmp),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (ready),
        .imem_rvalid (rvalid_q),
        .imem_rdata  (rdata_q),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .flush       (flush)
`ifdef FETCH_PERF_CNT_EN
        ,
        .redirect_cnt(redirect_cnt),
        .kill_cnt    (kill_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: reply exactly one cycle after acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= imem_req & ready;
            rdata_q  <= imem_addr + 32'h0050_0093;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    task automatic expect_if(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] instr);
        check({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, v});
        check({tag, ".if_pc"},    if_pc,    pc);
        check({tag, ".if_instr"}, if_instr, instr);
    endtask

    task automatic expect_req(input string tag, input logic req, input logic [31:0] addr);
        check({tag, ".imem_req"},  {31'b0, imem_req}, {31'b0, req});
        check({tag, ".imem_addr"}, imem_addr, addr);
    endtask

    task automatic expect_flush(input string tag, input logic f);
        check({tag, ".flush"}, {31'b0, flush}, {31'b0, f});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        ready     = 1'b1;
        stall     = 1'b0;
        br_en     = 1'b0;
        ba        = 1'b0;
        jmp       = 1'b1;
        br_target = 32'h0000_0040;

        // Reset state; flush must stay low even with jmp asserted.
        #12;
        expect_flush("rst", 1'b0);
        expect_if("rst", 1'b0, 32'h0, NOP_INSTR);
        expect_req("rst", 1'b1, 32'h0);
        jmp = 1'b0;

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        expect_req("rel", 1'b1, 32'h0);

        // Sequential fetch: one instruction every two cycles.
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i % 2 == 1) begin
                expect_if("seq", 1'b1, 32'(4 * (i / 2)), 32'h0050_0093 + 32'(4 * (i / 2)));
                expect_req("seq", 1'b1, 32'(4 * (i / 2) + 4));
            end else begin
                check("seq.if_valid", {31'b0, if_valid}, 32'h0);
                check("seq.if_instr", if_instr, NOP_INSTR);
                check("seq.imem_req", {31'b0, imem_req}, 32'h0);
            end
        end

        // Stall for three edges while the response for 0xC returns.
        stall = 1'b1;
        cyc(); expect_if("stall_a", 1'b1, 32'h8, 32'h0050_009B); expect_req("stall_a", 1'b0, 32'hC);
        cyc(); expect_if("stall_b", 1'b1, 32'h8, 32'h0050_009B); expect_req("stall_b", 1'b0, 32'hC);
        cyc(); expect_if("stall_c", 1'b1, 32'h8, 32'h0050_009B); expect_req("stall_c", 1'b0, 32'hC);
        stall = 1'b0;
        cyc(); expect_if("unstall", 1'b1, 32'hC, 32'h0050_009F); expect_req("unstall", 1'b1, 32'h10);
        cyc(); expect_if("unstall_bub", 1'b0, 32'hC, NOP_INSTR);
        cyc(); expect_if("unstall_next", 1'b1, 32'h10, 32'h0050_00A3);
        expect_req("unstall_next", 1'b1, 32'h14);

        // Taken branch in S_WAIT while the response arrives.
        cyc(); expect_req("br_wait", 1'b0, 32'h14);
        br_en = 1'b1; ba = 1'b1; br_target = 32'h0000_0100;
        #1; expect_flush("br_wait", 1'b1);
        cyc(); br_en = 1'b0; ba = 1'b0;
        #1; expect_flush("br_wait_after", 1'b0);
        expect_req("br_wait_after", 1'b1, 32'h100);
        expect_if("br_wait_after", 1'b0, 32'h10, NOP_INSTR);
`ifdef FETCH_PERF_CNT_EN
        check("br_wait.kill_cnt", kill_cnt, 32'd1);
        check("br_wait.redirect_cnt", redirect_cnt, 32'd1);
`endif
        cyc();
        cyc(); expect_if("br_tgt", 1'b1, 32'h100, 32'h0050_0193); expect_req("br_tgt", 1'b1, 32'h104);

        // Not-taken branch: no flush, fetch continues sequentially.
        br_en = 1'b1; ba = 1'b0; br_target = 32'h0000_0300;
        #1; expect_flush("nt", 1'b0);
        cyc(); check("nt.if_valid", {31'b0, if_valid}, 32'h0);
        cyc(); expect_if("nt", 1'b1, 32'h104, 32'h0050_0197); expect_req("nt", 1'b1, 32'h108);
        br_en = 1'b0;

        // Jump in S_REQ on the accept cycle: the accepted reply is killed.
        jmp = 1'b1; br_target = 32'h0000_0200;
        #1; expect_flush("jmp_acc", 1'b1);
        cyc(); jmp = 1'b0;
        #1; expect_req("jmp_acc_wait", 1'b0, 32'h200);
        check("jmp_acc_wait.if_valid", {31'b0, if_valid}, 32'h0);
        cyc(); expect_req("jmp_acc_drop", 1'b1, 32'h200);
        check("jmp_acc_drop.if_valid", {31'b0, if_valid}, 32'h0);
        cyc();
        cyc(); expect_if("jmp_acc", 1'b1, 32'h200, 32'h0050_0293); expect_req("jmp_acc", 1'b1, 32'h204);

        // Jump in S_REQ while the request is not accepted.
        ready = 1'b0;
        cyc(); expect_req("noacc", 1'b1, 32'h204);
        jmp = 1'b1; br_target = 32'h0000_0300;
        #1; expect_flush("noacc", 1'b1);
        cyc(); jmp = 1'b0;
        #1; expect_req("noacc_tgt", 1'b1, 32'h300);
        ready = 1'b1;
        cyc();
        cyc(); expect_if("noacc", 1'b1, 32'h300, 32'h0050_0393); expect_req("noacc", 1'b1, 32'h304);

        // Jump while stalled in S_HOLD: parked response discarded.
        stall = 1'b1;
        cyc(); expect_if("hold_a", 1'b1, 32'h300, 32'h0050_0393);
        cyc(); expect_req("hold_b", 1'b0, 32'h304);
        jmp = 1'b1; br_target = 32'h0000_0400;
        #1; expect_flush("hold", 1'b1);
        cyc(); jmp = 1'b0; stall = 1'b0;
        #1; expect_req("hold_tgt", 1'b1, 32'h400);
        check("hold_tgt.if_valid", {31'b0, if_valid}, 32'h0);
        cyc();
        cyc(); expect_if("hold", 1'b1, 32'h400, 32'h0050_0493); expect_req("hold", 1'b1, 32'h404);

        // Jump to the top word (unaligned target) and wrap the PC to 0.
        jmp = 1'b1; br_target = 32'hFFFF_FFFF;
        #1; expect_flush("wrap", 1'b1);
        cyc(); jmp = 1'b0;
        #1; expect_req("wrap_tgt", 1'b0, 32'hFFFF_FFFC);
        cyc();
        cyc();
        cyc(); expect_if("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0050_008F); expect_req("wrap", 1'b1, 32'h0);

        // Unaligned branch target 0x103 fetches from 0x100.
        br_en = 1'b1; ba = 1'b1; br_target = 32'h0000_0103;
        #1; expect_flush("unal", 1'b1);
        cyc(); br_en = 1'b0; ba = 1'b0;
        #1; check("unal.imem_addr", imem_addr, 32'h100);
        cyc(); expect_req("unal_req", 1'b1, 32'h100);
        cyc();
        cyc(); expect_if("unal", 1'b1, 32'h100, 32'h0050_0193);
`ifdef FETCH_PERF_CNT_EN
        check("end.kill_cnt", kill_cnt, 32'd5);
        check("end.redirect_cnt", redirect_cnt, 32'd6);
`endif

        // Reset mid-operation takes effect immediately.
        #2; jmp = 1'b1; br_target = 32'h0000_0500;
        rst_n = 1'b0;
        #1;
        expect_flush("midrst", 1'b0);
        expect_if("midrst", 1'b0, 32'h0, NOP_INSTR);
        expect_req("midrst", 1'b1, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("midrst.kill_cnt", kill_cnt, 32'd0);
        check("midrst.redirect_cnt", redirect_cnt, 32'd0);
`endif
        jmp = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
